// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_pkg
// Description : Shared constants, sequencer state type and the one-hot to
//               index helper for the interrupt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

    localparam int NUM_INTR    = 8;
    localparam int STACK_DEPTH = 8;
    localparam int IDX_W       = $clog2(NUM_INTR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        RETURN = 2'd3
    } intr_seq_state_t;

    // Binary index of the set bit of a one-hot vector (0 when the vector is 0).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_INTR-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_INTR; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : intr_pkg
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : LIFO of return addresses. Only the pointer is reset; the
//               storage array keeps whatever it held.
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
    import intr_pkg::*;
#(
    parameter  int DEPTH  = STACK_DEPTH,
    parameter  int WIDTH  = 10,
    localparam int LVL_W  = $clog2(DEPTH + 1),
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [LVL_W-1:0] ptr_q;
    logic [LVL_W-1:0] ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full  = (ptr_q == LVL_W'(DEPTH));
    assign empty = (ptr_q == '0);
    assign level = ptr_q;
    // Top of stack is the entry just below the pointer; read as 0 when empty.
    assign rdata = empty ? '0 : mem_q[ADDR_W'(ptr_q - LVL_W'(1))];

    // Pointer update; pushes into a full stack and pops from an empty one are ignored.
    always_comb begin
        ptr_d = ptr_q;
        if (push && !full) begin
            ptr_d = ptr_q + LVL_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - LVL_W'(1);
        end
    end

    // Pointer register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage write at the current pointer; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[ADDR_W'(ptr_q)] <= wdata;
        end
    end

endmodule : ret_stack
`default_nettype wire

// File: rtl/intr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : intr_sequencer
// Description : Decides at instruction boundaries whether to enter an
//               interrupt, saves/restores the return PC on a return stack and
//               pulses call_intr / s_return_intr / pc_load.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_sequencer
    import intr_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = 10'h3F8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_INTR-1:0] min_bit_s,
    input  logic [NUM_INTR-1:0] min_bit_a,
    input  logic                intr_enable,
    input  logic                instr_boundary,
    input  logic [PC_W-1:0]     pc_current,
    input  logic                reti,
    output logic [NUM_INTR-1:0] call_intr,
    output logic [NUM_INTR-1:0] s_return_intr,
    output logic                pc_load,
    output logic [PC_W-1:0]     pc_next,
    output logic                stall,
    output logic [3:0]          nest_level,
    output logic                stack_err
);

    intr_seq_state_t     state_q, state_d;
    logic [NUM_INTR-1:0] cur_line_q, cur_line_d;
    logic [NUM_INTR-1:0] ret_line_q, ret_line_d;
    logic [PC_W-1:0]     save_pc_q, save_pc_d;
    logic                stack_err_q, stack_err_d;

    logic                stk_push;
    logic                stk_pop;
    logic                stk_full;
    logic                stk_empty;
    logic [PC_W-1:0]     stk_top;
    logic [3:0]          stk_level;
    logic                accept_req;
    logic [PC_W-1:0]     vector_addr;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .wdata (save_pc_q),
        .rdata (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .level (stk_level)
    );

    // A request wins only if it is strictly higher priority (numerically smaller one-hot)
    // than the line already in service; equal priority never preempts.
    assign accept_req = intr_enable && instr_boundary && (min_bit_s != '0) &&
                        ((min_bit_a == '0) || (min_bit_s < min_bit_a));

    assign vector_addr = {VEC_BASE[PC_W-1:3], onehot_to_idx(cur_line_q)};

    // Next-state logic: reti has priority over an accept in IDLE.
    always_comb begin
        state_d     = state_q;
        cur_line_d  = cur_line_q;
        ret_line_d  = ret_line_q;
        save_pc_d   = save_pc_q;
        stack_err_d = stack_err_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (reti) begin
                    state_d    = RETURN;
                    ret_line_d = min_bit_a;
                end else if (accept_req) begin
                    if (stk_full) begin
                        stack_err_d = 1'b1;
                    end else begin
                        state_d    = SAVE;
                        cur_line_d = min_bit_s;
                        save_pc_d  = pc_current;
                    end
                end
            end
            SAVE: begin
                stk_push = 1'b1;
                state_d  = VECTOR;
            end
            VECTOR: begin
                state_d = IDLE;
            end
            RETURN: begin
                if (stk_empty) begin
                    stack_err_d = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from state and registers, so no input reaches them combinationally.
    always_comb begin
        call_intr     = '0;
        s_return_intr = '0;
        pc_load       = 1'b0;
        pc_next       = '0;
        case (state_q)
            VECTOR: begin
                call_intr = cur_line_q;
                pc_load   = 1'b1;
                pc_next   = vector_addr;
            end
            RETURN: begin
                if (!stk_empty) begin
                    s_return_intr = ret_line_q;
                    pc_load       = 1'b1;
                    pc_next       = stk_top;
                end
            end
            default: begin
                call_intr = '0;
            end
        endcase
    end

    assign stall      = (state_q != IDLE);
    assign nest_level = stk_level;
    assign stack_err  = stack_err_q;

    // State and context registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_line_q  <= '0;
            ret_line_q  <= '0;
            save_pc_q   <= '0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_line_q  <= cur_line_d;
            ret_line_q  <= ret_line_d;
            save_pc_q   <= save_pc_d;
            stack_err_q <= stack_err_d;
        end
    end

endmodule : intr_sequencer
`default_nettype wire

// File: tb/tb_intr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_sequencer
// Description : Self-checking bench for intr_sequencer: directed scenarios
//               followed by randomized traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_sequencer;

    typedef struct packed {
        logic [7:0] call;
        logic [7:0] sret;
        logic       load;
        logic [9:0] pcn;
        logic [3:0] lvl;
        logic       stall;
        logic       err;
    } out_t;

    logic       clk;
    logic       reset;
    logic [7:0] min_bit_s;
    logic [7:0] min_bit_a;
    logic       intr_enable;
    logic       instr_boundary;
    logic [9:0] pc_current;
    logic       reti;
    logic [7:0] call_intr;
    logic [7:0] s_return_intr;
    logic       pc_load;
    logic [9:0] pc_next;
    logic       stall;
    logic [3:0] nest_level;
    logic       stack_err;
    out_t       obs;

    int n_checks = 0;
    int n_fail   = 0;

    intr_sequencer #(
        .PC_W     (10),
        .VEC_BASE (10'h3F8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .min_bit_s      (min_bit_s),
        .min_bit_a      (min_bit_a),
        .intr_enable    (intr_enable),
        .instr_boundary (instr_boundary),
        .pc_current     (pc_current),
        .reti           (reti),
        .call_intr      (call_intr),
        .s_return_intr  (s_return_intr),
        .pc_load        (pc_load),
        .pc_next        (pc_next),
        .stall          (stall),
        .nest_level     (nest_level),
        .stack_err      (stack_err)
    );

    assign obs = {call_intr, s_return_intr, pc_load, pc_next, nest_level, stall, stack_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        min_bit_s      = 8'h00;
        min_bit_a      = 8'h00;
        intr_enable    = 1'b1;
        instr_boundary = 1'b0;
        pc_current     = 10'h000;
        reti           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected 0", obs);
        end
    endtask

    task automatic test_basic_call();
        min_bit_s = 8'h04; min_bit_a = 8'h00; intr_enable = 1'b1;
        instr_boundary = 1'b1; pc_current = 10'h123;
        tick();
        n_checks++;
        if ({stall, pc_load, call_intr} !== {1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL call_save: got %b/%b/%h expected 1/0/00", stall, pc_load, call_intr);
        end
        // Inputs change after the latch cycle and must not matter.
        min_bit_s = 8'h08; instr_boundary = 1'b0; pc_current = 10'($urandom);
        tick();
        n_checks++;
        if ({call_intr, pc_load, pc_next, nest_level} !== {8'h04, 1'b1, 10'h3FA, 4'd1}) begin
            n_fail++;
            $display("FAIL call_vector: got call=%h load=%b pc=%h lvl=%0d expected 04/1/3fa/1",
                     call_intr, pc_load, pc_next, nest_level);
        end
        min_bit_s = 8'h00;
        tick();
        n_checks++;
        if ({stall, pc_load, call_intr, nest_level} !== {1'b0, 1'b0, 8'h00, 4'd1}) begin
            n_fail++;
            $display("FAIL call_done: got %b/%b/%h/%0d expected 0/0/00/1", stall, pc_load, call_intr, nest_level);
        end
    endtask

    task automatic test_preempt();
        min_bit_a = 8'h04; min_bit_s = 8'h01; instr_boundary = 1'b1; pc_current = 10'h2A5;
        tick();
        min_bit_s = 8'h00; instr_boundary = 1'b0;
        tick();
        n_checks++;
        if ({call_intr, pc_load, pc_next, nest_level} !== {8'h01, 1'b1, 10'h3F8, 4'd2}) begin
            n_fail++;
            $display("FAIL preempt_vector: got call=%h load=%b pc=%h lvl=%0d expected 01/1/3f8/2",
                     call_intr, pc_load, pc_next, nest_level);
        end
        tick();
        // Lower-priority request against line 2 in service: ignored.
        min_bit_a = 8'h04; min_bit_s = 8'h10; instr_boundary = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({stall, nest_level} !== {1'b0, 4'd2}) begin
                n_fail++;
                $display("FAIL lower_prio_blocked: got stall=%b lvl=%0d expected 0/2", stall, nest_level);
            end
        end
        min_bit_s = 8'h00; instr_boundary = 1'b0;
    endtask

    task automatic test_return();
        min_bit_a = 8'h01; reti = 1'b1;
        tick();
        reti = 1'b0; min_bit_a = 8'h00;
        n_checks++;
        if ({s_return_intr, pc_load, pc_next, nest_level, stall} !== {8'h01, 1'b1, 10'h2A5, 4'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL return_1: got sret=%h load=%b pc=%h lvl=%0d stall=%b expected 01/1/2a5/2/1",
                     s_return_intr, pc_load, pc_next, nest_level, stall);
        end
        tick();
        min_bit_a = 8'h04; reti = 1'b1;
        tick();
        reti = 1'b0; min_bit_a = 8'h00;
        n_checks++;
        if ({s_return_intr, pc_load, pc_next} !== {8'h04, 1'b1, 10'h123}) begin
            n_fail++;
            $display("FAIL return_2: got sret=%h load=%b pc=%h expected 04/1/123", s_return_intr, pc_load, pc_next);
        end
        tick();
        n_checks++;
        if ({nest_level, stall, s_return_intr} !== {4'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL return_done: got lvl=%0d stall=%b sret=%h expected 0/0/00", nest_level, stall, s_return_intr);
        end
    endtask

    task automatic test_reti_vs_accept();
        min_bit_s = 8'h02; instr_boundary = 1'b1; pc_current = 10'h055;
        tick();
        min_bit_s = 8'h00; instr_boundary = 1'b0;
        tick();
        tick();
        // Simultaneous reti and valid accept.
        reti = 1'b1; min_bit_a = 8'h02; min_bit_s = 8'h01; instr_boundary = 1'b1; pc_current = 10'h077;
        tick();
        reti = 1'b0; min_bit_a = 8'h00;
        n_checks++;
        if ({s_return_intr, pc_load, pc_next, call_intr} !== {8'h02, 1'b1, 10'h055, 8'h00}) begin
            n_fail++;
            $display("FAIL reti_first: got sret=%h load=%b pc=%h call=%h expected 02/1/055/00",
                     s_return_intr, pc_load, pc_next, call_intr);
        end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reti_back_idle: got stall=%b expected 0", stall);
        end
        tick();
        min_bit_s = 8'h00; instr_boundary = 1'b0;
        tick();
        n_checks++;
        if ({call_intr, pc_load, pc_next, nest_level} !== {8'h01, 1'b1, 10'h3F8, 4'd1}) begin
            n_fail++;
            $display("FAIL accept_after_reti: got call=%h load=%b pc=%h lvl=%0d expected 01/1/3f8/1",
                     call_intr, pc_load, pc_next, nest_level);
        end
        tick();
        min_bit_a = 8'h01; reti = 1'b1;
        tick();
        reti = 1'b0; min_bit_a = 8'h00;
        n_checks++;
        if (pc_next !== 10'h077) begin
            n_fail++;
            $display("FAIL reti_vs_accept_pc: got %h expected 077", pc_next);
        end
        tick();
    endtask

    task automatic test_underflow_and_reset();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_checks++;
        if ({stall, pc_load, s_return_intr, stack_err} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL underflow_return: got stall=%b load=%b sret=%h err=%b expected 1/0/00/0",
                     stall, pc_load, s_return_intr, stack_err);
        end
        tick();
        n_checks++;
        if ({stall, stack_err, nest_level} !== {1'b0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL underflow_err: got stall=%b err=%b lvl=%0d expected 0/1/0", stall, stack_err, nest_level);
        end
        min_bit_s = 8'h04; instr_boundary = 1'b1; pc_current = 10'h1AB;
        tick();
        min_bit_s = 8'h00; instr_boundary = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_save: got %h expected 0", obs);
        end
        #2;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL sequence_abandoned: got %h expected 0", obs);
            end
        end
    endtask

    task automatic test_enable();
        intr_enable = 1'b0; min_bit_s = 8'h02; instr_boundary = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({stall, nest_level} !== {1'b0, 4'd0}) begin
                n_fail++;
                $display("FAIL enable_blocks: got stall=%b lvl=%0d expected 0/0", stall, nest_level);
            end
        end
        intr_enable = 1'b1;
        tick();
        min_bit_s = 8'h00; instr_boundary = 1'b0;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_accept: got stall=%b expected 1", stall);
        end
        tick();
        n_checks++;
        if ({call_intr, pc_next} !== {8'h02, 10'h3F9}) begin
            n_fail++;
            $display("FAIL enable_vector: got call=%h pc=%h expected 02/3f9", call_intr, pc_next);
        end
        tick();
        min_bit_a = 8'h02; reti = 1'b1;
        tick();
        reti = 1'b0; min_bit_a = 8'h00;
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            min_bit_s = 8'h01; instr_boundary = 1'b1; pc_current = 10'h100 + 10'(i);
            tick();
            min_bit_s = 8'h00; instr_boundary = 1'b0;
            tick();
            tick();
        end
        n_checks++;
        if ({nest_level, stack_err} !== {4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL stack_full: got lvl=%0d err=%b expected 8/0", nest_level, stack_err);
        end
        min_bit_s = 8'h01; instr_boundary = 1'b1;
        tick();
        min_bit_s = 8'h00; instr_boundary = 1'b0;
        n_checks++;
        if ({stall, stack_err, nest_level} !== {1'b0, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL overflow: got stall=%b err=%b lvl=%0d expected 0/1/8", stall, stack_err, nest_level);
        end
        for (int i = 7; i >= 0; i--) begin
            min_bit_a = 8'h01; reti = 1'b1;
            tick();
            reti = 1'b0; min_bit_a = 8'h00;
            n_checks++;
            if ({pc_load, pc_next} !== {1'b1, 10'h100 + 10'(i)}) begin
                n_fail++;
                $display("FAIL lifo_order[%0d]: got load=%b pc=%h expected 1/%h", i, pc_load, pc_next, 10'h100 + 10'(i));
            end
            tick();
        end
        n_checks++;
        if ({nest_level, stack_err} !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL drained: got lvl=%0d err=%b expected 0/1", nest_level, stack_err);
        end
    endtask

    // Transaction model: each decision enqueues the per-cycle outputs it will produce,
    // including a trailing idle cycle before the next decision can be made.
    task automatic test_random();
        logic [9:0] stk[$];
        out_t       expq[$];
        out_t       exp_o;
        out_t       act_o;
        out_t       idle_o;
        logic       err_m;
        int         lvl0;
        logic [9:0] vec;
        do_reset();
        err_m = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            min_bit_s      = ($urandom % 3 == 0) ? 8'h00 : 8'h01 << ($urandom % 8);
            min_bit_a      = ($urandom % 3 == 0) ? 8'h00 : 8'h01 << ($urandom % 8);
            intr_enable    = ($urandom % 4 != 0);
            instr_boundary = ($urandom % 2 == 0);
            pc_current     = 10'($urandom);
            reti           = ($urandom % 6 == 0);
            lvl0 = stk.size();
            if (expq.size() > 0) begin
                exp_o = expq.pop_front();
            end else if (reti) begin
                exp_o = '0;
                exp_o.stall = 1'b1;
                exp_o.lvl   = 4'(lvl0);
                exp_o.err   = err_m;
                if (lvl0 > 0) begin
                    exp_o.sret = min_bit_a;
                    exp_o.load = 1'b1;
                    exp_o.pcn  = stk.pop_back();
                end else begin
                    err_m = 1'b1;
                end
                idle_o = '0;
                idle_o.lvl = 4'(stk.size());
                idle_o.err = err_m;
                expq.push_back(idle_o);
            end else if (intr_enable && instr_boundary && min_bit_s != 0 &&
                         (min_bit_a == 0 || min_bit_s < min_bit_a)) begin
                if (lvl0 == 8) begin
                    err_m = 1'b1;
                    exp_o = '0;
                    exp_o.lvl = 4'd8;
                    exp_o.err = 1'b1;
                end else begin
                    stk.push_back(pc_current);
                    vec = 10'h3F8;
                    for (int b = 0; b < 8; b++) if (min_bit_s[b]) vec = 10'h3F8 + 10'(b);
                    exp_o = '0;
                    exp_o.stall = 1'b1;
                    exp_o.lvl   = 4'(lvl0);
                    exp_o.err   = err_m;
                    idle_o = '0;
                    idle_o.call  = min_bit_s;
                    idle_o.load  = 1'b1;
                    idle_o.pcn   = vec;
                    idle_o.lvl   = 4'(lvl0 + 1);
                    idle_o.stall = 1'b1;
                    idle_o.err   = err_m;
                    expq.push_back(idle_o);
                    idle_o = '0;
                    idle_o.lvl = 4'(lvl0 + 1);
                    idle_o.err = err_m;
                    expq.push_back(idle_o);
                end
            end else begin
                exp_o = '0;
                exp_o.lvl = 4'(lvl0);
                exp_o.err = err_m;
            end
            tick();
            act_o = obs;
            // pc_next is only meaningful while pc_load is expected.
            if (!exp_o.load) act_o.pcn = 10'h000;
            n_checks++;
            if (act_o !== exp_o) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", cyc, act_o, exp_o);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_call();
        test_preempt();
        test_return();
        test_reti_vs_accept();
        test_underflow_and_reset();
        test_enable();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_intr_sequencer
`default_nettype wire
